// File: rtl/c_multi_hot_err_monitor_if.sv
// Purpose: bundles the monitored vector, its qualifier/clear controls and the
//          monitor status outputs of c_multi_hot_err_monitor.
// Signals:
//   active       - data is meaningful this cycle
//   data         - monitored vector, [0:width-1], bit 0 is the MSB
//   clear        - synchronous clear of sticky/count/capture state
//   error_pulse  - one-cycle pulse per detected violation
//   error_sticky - set on first violation, held until clear
//   error_count  - saturating violation count
//   cap_data     - first offending vector since reset/clear
//   cap_valid    - cap_data holds a captured vector
//   saturated    - error_count is all ones
// Modports: master drives the vector and controls; slave is the monitor.
interface c_multi_hot_err_monitor_if #(
    parameter int unsigned width     = 5,
    parameter int unsigned cnt_width = 8
);
    logic                 active;
    logic [0:width-1]     data;
    logic                 clear;
    logic                 error_pulse;
    logic                 error_sticky;
    logic [cnt_width-1:0] error_count;
    logic [0:width-1]     cap_data;
    logic                 cap_valid;
    logic                 saturated;

    modport master (
        output active, data, clear,
        input  error_pulse, error_sticky, error_count, cap_data, cap_valid, saturated
    );

    modport slave (
        input  active, data, clear,
        output error_pulse, error_sticky, error_count, cap_data, cap_valid, saturated
    );
endinterface

// File: rtl/c_multi_hot_err_monitor.sv
// Purpose: c_multi_hot_det flags a vector with more than one bit set;
//          c_multi_hot_err_monitor registers a one-hot control vector, detects
//          multi-hot (optionally zero-hot) violations two cycles later, keeps a
//          saturating error count, a sticky flag and a capture of the first
//          offending vector.
// Ports (c_multi_hot_err_monitor):
//   clk     - rising-edge clock
//   reset_n - asynchronous active-low reset
//   bus     - slave modport of c_multi_hot_err_monitor_if (vector, controls, status)

// Combinational multi-hot detector over a [0:width-1] vector.
module c_multi_hot_det #(
    parameter int unsigned width = 5
) (
    input  logic [0:width-1] data,
    output logic             multi_hot_c
);
    logic seen;

    // Running OR of earlier bits; a set bit after any earlier set bit is multi-hot.
    always_comb begin
        seen        = 1'b0;
        multi_hot_c = 1'b0;
        for (int i = 0; i < int'(width); i++) begin
            multi_hot_c = multi_hot_c | (seen & data[i]);
            seen        = seen | data[i];
        end
    end
endmodule

module c_multi_hot_err_monitor #(
    parameter int unsigned width      = 5,
    parameter int unsigned cnt_width  = 8,
    parameter int unsigned check_zero = 0
) (
    input  logic                      clk,
    input  logic                      reset_n,
    c_multi_hot_err_monitor_if.slave  bus
);
    localparam logic                 zero_chk = (check_zero != 0);
    localparam logic [cnt_width-1:0] cnt_max  = '1;
    localparam logic [cnt_width-1:0] cnt_one  = cnt_width'(1);

    typedef enum logic [1:0] {
        st_ok  = 2'd0,
        st_err = 2'd1,
        st_sat = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 active_q;
    logic [0:width-1]     data_q;
    logic [cnt_width-1:0] count_q, count_d, count_inc_c;
    logic [0:width-1]     cap_data_q, cap_data_d;
    logic                 cap_valid_q, cap_valid_d;
    logic                 pulse_q;
    logic                 sticky_q;
    logic                 sat_q;
    logic                 multi_hot_c;
    logic                 viol_c;

    c_multi_hot_det #(.width(width)) u_det (
        .data        (data_q),
        .multi_hot_c (multi_hot_c)
    );

    // Stage-2 violation decision on the registered vector.
    assign viol_c      = active_q & (multi_hot_c | (zero_chk & ~(|data_q)));
    assign count_inc_c = count_q + cnt_one;

    // Next state, count and capture; clear overrides any concurrent violation.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        cap_data_d  = cap_data_q;
        cap_valid_d = cap_valid_q;
        if (bus.clear) begin
            state_d     = st_ok;
            count_d     = '0;
            cap_data_d  = '0;
            cap_valid_d = 1'b0;
        end else if (viol_c) begin
            unique case (state_q)
                st_ok: begin
                    count_d     = cnt_one;
                    cap_data_d  = data_q;
                    cap_valid_d = 1'b1;
                    state_d     = (cnt_max == cnt_one) ? st_sat : st_err;
                end
                st_err: begin
                    count_d = count_inc_c;
                    state_d = (count_inc_c == cnt_max) ? st_sat : st_err;
                end
                st_sat: begin
                    count_d = cnt_max;
                end
                default: begin
                    state_d = st_ok;
                end
            endcase
        end
    end

    // Stage-1 capture, FSM state and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            active_q    <= 1'b0;
            data_q      <= '0;
            state_q     <= st_ok;
            count_q     <= '0;
            cap_data_q  <= '0;
            cap_valid_q <= 1'b0;
            pulse_q     <= 1'b0;
            sticky_q    <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            active_q    <= bus.active;
            data_q      <= bus.data;
            state_q     <= state_d;
            count_q     <= count_d;
            cap_data_q  <= cap_data_d;
            cap_valid_q <= cap_valid_d;
            pulse_q     <= viol_c;
            sticky_q    <= (state_d != st_ok);
            sat_q       <= (state_d == st_sat);
        end
    end

    assign bus.error_pulse  = pulse_q;
    assign bus.error_sticky = sticky_q;
    assign bus.error_count  = count_q;
    assign bus.cap_data     = cap_data_q;
    assign bus.cap_valid    = cap_valid_q;
    assign bus.saturated    = sat_q;
endmodule

// File: tb/tb_c_multi_hot_err_monitor.sv
// Purpose: scoreboard bench for c_multi_hot_err_monitor (width=5, cnt_width=3).
// dut0 runs with check_zero=0, dut1 with check_zero=1. Each directed row drives
// one cycle of input and queues the hand-computed outputs expected two cycles later.
module tb_c_multi_hot_err_monitor;
    logic clk;
    logic reset_n;
    int unsigned cyc;
    int checks;
    int failures;

    typedef struct {
        int unsigned due;
        bit          sel;
        bit          p;
        int unsigned cnt;
        bit          stk;
        bit          sat;
        bit          cv;
        logic [4:0]  cd;
    } exp_t;

    exp_t q[$];

    c_multi_hot_err_monitor_if #(.width(5), .cnt_width(3)) if0 ();
    c_multi_hot_err_monitor_if #(.width(5), .cnt_width(3)) if1 ();

    c_multi_hot_err_monitor #(.width(5), .cnt_width(3), .check_zero(0)) dut0 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if0)
    );

    c_multi_hot_err_monitor #(.width(5), .cnt_width(3), .check_zero(1)) dut1 (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (if1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic cmp(input string name, input int unsigned act, input int unsigned expv);
        checks++;
        if (act != expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Drive one input cycle on the selected DUT and queue its expected outputs.
    task automatic step(input bit sel, input bit clr, input bit act, input logic [4:0] d,
                        input bit p, input int unsigned cnt, input bit stk, input bit sat,
                        input bit cv, input logic [4:0] cd);
        exp_t e;
        @(posedge clk);
        #1;
        if (sel == 1'b0) begin
            if0.clear = clr; if0.active = act; if0.data = d;
            if1.clear = 1'b0; if1.active = 1'b0; if1.data = '0;
        end else begin
            if1.clear = clr; if1.active = act; if1.data = d;
            if0.clear = 1'b0; if0.active = 1'b0; if0.data = '0;
        end
        e.due = cyc + 2; e.sel = sel; e.p = p; e.cnt = cnt;
        e.stk = stk; e.sat = sat; e.cv = cv; e.cd = cd;
        q.push_back(e);
    endtask

    task automatic idle_inputs();
        if0.clear = 1'b0; if0.active = 1'b0; if0.data = '0;
        if1.clear = 1'b0; if1.active = 1'b0; if1.data = '0;
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge clk);
        #1;
        cmp("queue_drained", q.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        cmp({tag, "_pulse0"},  if0.error_pulse,  0);
        cmp({tag, "_sticky0"}, if0.error_sticky, 0);
        cmp({tag, "_count0"},  if0.error_count,  0);
        cmp({tag, "_cap0"},    if0.cap_data,     0);
        cmp({tag, "_capv0"},   if0.cap_valid,    0);
        cmp({tag, "_sat0"},    if0.saturated,    0);
        cmp({tag, "_count1"},  if1.error_count,  0);
        cmp({tag, "_sticky1"}, if1.error_sticky, 0);
    endtask

    // Monitor: compare the queued expectation due in this cycle.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() != 0 && q[0].due < cyc) begin
            e = q.pop_front();
            cmp($sformatf("stale_entry_due%0d", e.due), cyc, e.due);
        end else if (q.size() != 0 && q[0].due == cyc) begin
            e = q.pop_front();
            if (e.sel == 1'b0) begin
                cmp($sformatf("pulse0@%0d", cyc),  if0.error_pulse,  e.p);
                cmp($sformatf("count0@%0d", cyc),  if0.error_count,  e.cnt);
                cmp($sformatf("sticky0@%0d", cyc), if0.error_sticky, e.stk);
                cmp($sformatf("sat0@%0d", cyc),    if0.saturated,    e.sat);
                cmp($sformatf("capv0@%0d", cyc),   if0.cap_valid,    e.cv);
                cmp($sformatf("cap0@%0d", cyc),    if0.cap_data,     e.cd);
            end else begin
                cmp($sformatf("pulse1@%0d", cyc),  if1.error_pulse,  e.p);
                cmp($sformatf("count1@%0d", cyc),  if1.error_count,  e.cnt);
                cmp($sformatf("sticky1@%0d", cyc), if1.error_sticky, e.stk);
                cmp($sformatf("sat1@%0d", cyc),    if1.saturated,    e.sat);
                cmp($sformatf("capv1@%0d", cyc),   if1.cap_valid,    e.cv);
                cmp($sformatf("cap1@%0d", cyc),    if1.cap_data,     e.cd);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0; failures = 0; cyc = 0;
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_all_zero("por");
        reset_n = 1'b1;

        // Sweep of all 32 values: pulses only for popcount > 1; first capture is 3.
        step(0,0,1,5'd0 ,0,0,0,0,0,5'd0);
        step(0,0,1,5'd1 ,0,0,0,0,0,5'd0);
        step(0,0,1,5'd2 ,0,0,0,0,0,5'd0);
        step(0,0,1,5'd3 ,1,1,1,0,1,5'd3);
        step(0,0,1,5'd4 ,0,1,1,0,1,5'd3);
        step(0,0,1,5'd5 ,1,2,1,0,1,5'd3);
        step(0,0,1,5'd6 ,1,3,1,0,1,5'd3);
        step(0,0,1,5'd7 ,1,4,1,0,1,5'd3);
        step(0,0,1,5'd8 ,0,4,1,0,1,5'd3);
        step(0,0,1,5'd9 ,1,5,1,0,1,5'd3);
        step(0,0,1,5'd10,1,6,1,0,1,5'd3);
        step(0,0,1,5'd11,1,7,1,1,1,5'd3);
        step(0,0,1,5'd12,1,7,1,1,1,5'd3);
        step(0,0,1,5'd13,1,7,1,1,1,5'd3);
        step(0,0,1,5'd14,1,7,1,1,1,5'd3);
        step(0,0,1,5'd15,1,7,1,1,1,5'd3);
        step(0,0,1,5'd16,0,7,1,1,1,5'd3);
        for (int v = 17; v < 32; v++) step(0,0,1,5'(v),1,7,1,1,1,5'd3);
        step(0,0,0,5'd0 ,0,7,1,1,1,5'd3);
        step(0,0,0,5'd0 ,0,0,0,0,0,5'd0);   // observed after the clear below
        step(0,1,0,5'd0 ,0,0,0,0,0,5'd0);

        // Two violations: capture keeps the first.
        step(0,0,1,5'b00110,1,1,1,0,1,5'b00110);
        step(0,0,1,5'b11000,1,2,1,0,1,5'b00110);
        step(0,0,0,5'd0     ,0,2,1,0,1,5'b00110);
        step(0,0,0,5'd0     ,0,0,0,0,0,5'd0);
        step(0,1,0,5'd0     ,0,0,0,0,0,5'd0);

        // Nine violations: saturate on the 7th, keep pulsing.
        step(0,0,1,5'd31,1,1,1,0,1,5'd31);
        step(0,0,1,5'd31,1,2,1,0,1,5'd31);
        step(0,0,1,5'd31,1,3,1,0,1,5'd31);
        step(0,0,1,5'd31,1,4,1,0,1,5'd31);
        step(0,0,1,5'd31,1,5,1,0,1,5'd31);
        step(0,0,1,5'd31,1,6,1,0,1,5'd31);
        step(0,0,1,5'd31,1,7,1,1,1,5'd31);
        step(0,0,1,5'd31,1,7,1,1,1,5'd31);
        step(0,0,1,5'd31,1,7,1,1,1,5'd31);
        step(0,0,0,5'd0 ,0,7,1,1,1,5'd31);

        // Clear on the same edge as a violation; the next vector is still recorded.
        step(0,0,1,5'd3 ,1,0,0,0,0,5'd0);
        step(0,1,1,5'd5 ,1,1,1,0,1,5'd5);
        step(0,0,0,5'd0 ,0,1,1,0,1,5'd5);

        // Build up to count 4, then an inactive all-ones vector.
        step(0,0,1,5'b01010,1,2,1,0,1,5'd5);
        step(0,0,1,5'b01010,1,3,1,0,1,5'd5);
        step(0,0,1,5'b01010,1,4,1,0,1,5'd5);
        step(0,0,0,5'd31    ,0,4,1,0,1,5'd5);
        step(0,0,0,5'd0     ,0,4,1,0,1,5'd5);
        drain();

        // Mid-operation async reset clears outputs immediately.
        @(posedge clk);
        #2;
        cmp("pre_reset_count", if0.error_count, 4);
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        step(0,0,1,5'b10001,1,1,1,0,1,5'b10001);
        step(0,0,0,5'd0    ,0,1,1,0,1,5'b10001);

        // check_zero=1: all-zero active vector is a violation; inactive is ignored.
        step(1,0,1,5'd0 ,1,1,1,0,1,5'd0);
        step(1,0,0,5'd31,0,1,1,0,1,5'd0);
        step(1,0,1,5'd8 ,0,1,1,0,1,5'd0);
        step(1,0,1,5'd0 ,1,2,1,0,1,5'd0);
        step(1,0,0,5'd0 ,0,2,1,0,1,5'd0);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
